// File: rtl/uart_echo_buffer_pkg.sv
// Shared types for the UART echo path: transmit FSM states
// and default widths reused by the transmit-side blocks.
package uart_echo_buffer_pkg;

   localparam int DATA_W_DEF     = 8;
   localparam int DEPTH_LOG2_DEF = 4;
   localparam int BUSY_TO_DEF    = 16;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_BUSY,
      WAIT_DONE
   } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered read data and inferred RAM.
// Ports: clk, rst (async, active-low), push/din, pop/dout,
// count (0..2**DEPTH_LOG2), empty, full.
module uart_sync_fifo #(
   parameter int DATA_W     = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_W-1:0]     din,
   input  logic                  pop,
   output logic [DATA_W-1:0]     dout,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  empty,
   output logic                  full
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT =
      {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [DATA_W-1:0]     mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty;
   // A full FIFO still accepts a write when a read frees
   // the slot in the same cycle; the read sees old data.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            dout   <= mem[rd_ptr];
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_echo_buffer.sv
// Elastic byte buffer between UART receiver and transmitter.
// Ports: clk, rst (async, active-low), rx_data/rx_ready in,
// tx_busy in, tx_start/tx_data out, count/empty/full/overflow.
module uart_echo_buffer
   import uart_echo_buffer_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
   parameter int BUSY_TO    = BUSY_TO_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     rx_data,
   input  logic                  rx_ready,
   input  logic                  tx_busy,
   output logic                  tx_start,
   output logic [DATA_W-1:0]     tx_data,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow
);

   localparam int TW = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TO - 1);

   tx_state_e     state;
   logic [TW-1:0] timer;
   logic          pop;

   assign pop = (state == IDLE) && !empty && !tx_busy;

   // The FIFO read register doubles as the tx_data holding
   // register: it only changes on a pop, which only
   // happens back in IDLE.
   uart_sync_fifo #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_ready),
      .din   (rx_data),
      .pop   (pop),
      .dout  (tx_data),
      .count (count),
      .empty (empty),
      .full  (full)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow <= 1'b0;
      end else if (rx_ready && full && !pop) begin
         overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         tx_start <= 1'b0;
         timer    <= '0;
      end else begin
         tx_start <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pop) begin
                  state <= START;
               end
            end
            START: begin
               tx_start <= 1'b1;
               timer    <= '0;
               state    <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               // Transmitter never acknowledged: drop the byte.
               if (tx_busy) begin
                  state <= WAIT_DONE;
               end else if (timer == TO_LAST) begin
                  state <= IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Scoreboard bench for uart_echo_buffer with a reactive
// transmitter model and randomized byte traffic.
module tb_uart_echo_buffer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_ready = 1'b0;
   logic       tx_busy = 1'b0;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [4:0] count;
   logic       empty;
   logic       full;
   logic       overflow;

   uart_echo_buffer dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_ready (rx_ready),
      .tx_busy  (tx_busy),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .count    (count),
      .empty    (empty),
      .full     (full),
      .overflow (overflow)
   );

   initial forever #5 clk = ~clk;

   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;
   logic [7:0] exp_q[$];
   int start_cnt = 0;
   int start_prev = 0;
   int start_last = 0;
   bit resp_on = 0;
   bit len_rand = 0;
   int busy_len = 10;
   int busy_dly = 0;
   int model_cnt;
   bit model_ovf;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                    name, act, exp, cyc);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: every tx_start pops the scoreboard.
   initial begin
      logic       prev;
      logic [7:0] e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev = 1'b0;
         end else begin
            if (tx_start) begin
               chk("start_one_cycle", prev, 0);
               chk("busy_low_at_start", tx_busy, 0);
               start_prev = start_last;
               start_last = cyc;
               start_cnt++;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_start: tx_data %0h, none expected",
                           tx_data);
               end else begin
                  e = exp_q.pop_front();
                  chk("tx_data", tx_data, e);
               end
            end
            prev = tx_start;
         end
      end
   end

   // Transmitter model: busy rises after start, holds a while.
   initial begin
      int wl;
      int hl;
      logic s;
      wl = 0;
      hl = 0;
      forever begin
         @(negedge clk);
         s = tx_start && rst;
         #1;
         if (!resp_on) begin
            wl = 0;
            hl = 0;
         end else begin
            if (s) begin
               if (len_rand) begin
                  wl = $urandom_range(0, 3);
                  hl = $urandom_range(1, 25);
               end else begin
                  wl = busy_dly;
                  hl = busy_len;
               end
            end
            if (wl > 0) begin
               wl--;
            end else if (hl > 0) begin
               tx_busy = 1'b1;
               hl--;
            end else begin
               tx_busy = 1'b0;
            end
         end
      end
   end

   task automatic push_byte(input logic [7:0] d, input bit expect_it);
      rx_data = d;
      rx_ready = 1'b1;
      if (expect_it) exp_q.push_back(d);
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !tx_busy && count == 0 &&
             (cyc - start_last) > 40) break;
      end
      repeat (3) @(negedge clk);
      chk({name, "_drained"}, exp_q.size(), 0);
      chk({name, "_count0"}, count, 0);
      chk({name, "_empty"}, empty, 1);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      int peak;
      int n;
      logic [7:0] d;

      repeat (3) @(negedge clk);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_overflow", overflow, 0);
      rst = 1'b1;
      @(negedge clk);

      // Single byte with latency checks.
      resp_on = 1;
      busy_len = 10;
      busy_dly = 0;
      push_byte(8'h41, 1);
      chk("t1_count_push", count, 1);
      chk("t1_not_empty", empty, 0);
      @(negedge clk);
      chk("t1_count_pop", count, 0);
      chk("t1_empty_pop", empty, 1);
      chk("t1_no_early_start", tx_start, 0);
      @(negedge clk);
      chk("t1_start_latency", tx_start, 1);
      chk("t1_data", tx_data, 8'h41);
      drain("t1");

      // Burst into a slow transmitter.
      busy_len = 20;
      peak = 0;
      s0 = start_cnt;
      for (int i = 0; i < 5; i++) begin
         push_byte(8'h10 + 8'(i), 1);
         if (int'(count) > peak) peak = int'(count);
      end
      repeat (10) begin
         @(negedge clk);
         if (int'(count) > peak) peak = int'(count);
      end
      chk("t2_peak_4_5", (peak >= 4 && peak <= 5), 1);
      drain("t2");
      chk("t2_starts", start_cnt - s0, 5);

      // Random traffic, never more than a FIFO's worth.
      len_rand = 1;
      for (int r = 0; r < 3; r++) begin
         n = $urandom_range(1, 16);
         for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            push_byte(d, 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
         drain("rand");
      end
      chk("rand_no_overflow", overflow, 0);
      len_rand = 0;

      // Full FIFO, pop and push in the same cycle.
      resp_on = 0;
      tx_busy = 1'b1;
      for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i), 1);
      chk("t4_count16", count, 16);
      chk("t4_full", full, 1);
      tx_busy = 1'b0;
      rx_data = 8'hAA;
      rx_ready = 1'b1;
      exp_q.push_back(8'hAA);
      @(negedge clk);
      rx_ready = 1'b0;
      resp_on = 1;
      busy_len = 10;
      chk("t4_count_kept", count, 16);
      chk("t4_no_overflow", overflow, 0);
      chk("t4_still_full", full, 1);
      drain("t4");

      // Overflow: nothing drains while busy is stuck.
      resp_on = 0;
      tx_busy = 1'b1;
      model_cnt = 0;
      model_ovf = 0;
      for (int i = 0; i < 18; i++) begin
         d = 8'($urandom);
         if (model_cnt < 16) begin
            push_byte(d, 1);
            model_cnt++;
         end else begin
            push_byte(d, 0);
            model_ovf = 1;
         end
      end
      chk("t3_count", count, model_cnt);
      chk("t3_full", full, 1);
      chk("t3_overflow", overflow, model_ovf);
      tx_busy = 1'b0;
      resp_on = 1;
      drain("t3");
      chk("t3_overflow_sticky", overflow, model_ovf);

      // Busy timeout: transmitter never answers.
      resp_on = 0;
      tx_busy = 1'b0;
      s0 = start_cnt;
      push_byte(8'h5A, 1);
      push_byte(8'h5B, 1);
      for (int k = 0; k < 100; k++) begin
         if (start_cnt >= s0 + 2) break;
         @(negedge clk);
      end
      chk("t5_two_starts", start_cnt - s0, 2);
      chk("t5_timeout_gap", start_last - start_prev, 18);
      repeat (30) @(negedge clk);
      chk("t5_no_retry", start_cnt - s0, 2);
      resp_on = 1;
      busy_len = 8;
      push_byte(8'h77, 1);
      drain("t5");

      // Async reset while a byte is in flight.
      busy_len = 30;
      s0 = start_cnt;
      for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i), 1);
      for (int k = 0; k < 50; k++) begin
         if (start_cnt != s0) break;
         @(negedge clk);
      end
      chk("t6_started", start_cnt - s0, 1);
      repeat (5) @(negedge clk);
      chk("t6_queued", count, 3);
      #3;
      rst = 1'b0;
      #1;
      chk("t6_rst_start", tx_start, 0);
      chk("t6_rst_data", tx_data, 0);
      chk("t6_rst_count", count, 0);
      chk("t6_rst_empty", empty, 1);
      chk("t6_rst_full", full, 0);
      chk("t6_rst_overflow", overflow, 0);
      exp_q.delete();
      resp_on = 0;
      tx_busy = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      s0 = start_cnt;
      repeat (25) @(negedge clk);
      chk("t6_quiet_after_rst", start_cnt - s0, 0);
      resp_on = 1;
      busy_len = 5;
      push_byte(8'h99, 1);
      drain("t6");
      chk("t6_resume", start_cnt - s0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
